// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard controller for a classic 5-stage in-order pipeline.
//               Drives the write enables and bubble (flush) controls of the
//               PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, covering
//               load-use stalls, control-flow redirects resolved at EX/MEM,
//               data-memory back-pressure and a sticky memory-timeout error.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_TIMEOUT   consecutive busy edges tolerated before the error state
//                 (0 disables the timeout)
// Optional feature macro
//   HAZARD_PERF_CNT_EN  when defined, builds the saturating stall/flush
//                       counters; otherwise both counter ports tie to 0.
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous active-high reset
//   id_rs, id_rt  in   5   source registers of the instruction in IF/ID
//   id_uses_rt    in   1   ID instruction reads rt as a source
//   ex_memread    in   1   ID/EX instruction is a load
//   ex_rt         in   5   ID/EX load destination
//   mem_redirect  in   1   taken branch / jump / jr at EX/MEM outputs
//   mem_busy      in   1   data memory not ready this cycle
//   pc_we .. memwb_we               out 1  register write enables
//   ifid_flush, idex_flush, exmem_flush out 1  insert bubble at next edge
//   timeout_err   out  1   sticky memory-timeout flag
//   stall_cycles  out  16  performance counter (pc_we low outside ERR)
//   flush_events  out  16  performance counter (accepted redirects)
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        mem_redirect,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        memwb_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        timeout_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    // 9-bit compare target so a timeout of 256 (counter wrap) is still exact.
    localparam logic [8:0] C_TIMEOUT = 9'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic [8:0]  cnt_inc;
    logic        load_use;

    // r0 is hard-wired zero, so a load "to r0" never creates a dependency.
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // ------------------------------------------------------------------
    // Hazard outputs: purely combinational, highest priority first.
    // ------------------------------------------------------------------
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (reset) begin
            // Pipeline keeps its normal-run controls while held in reset.
        end else if (state_q == S_ERR) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (mem_busy) begin
            // Full freeze; any pending redirect stays parked in EX/MEM.
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (mem_redirect) begin
            // Kill the three younger instructions; a load-use is moot.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM next state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        cnt_inc       = {1'b0, wait_cnt_q} + 9'd1;
        case (state_q)
            S_RUN, S_WAIT: begin
                if (mem_busy) begin
                    wait_cnt_d = cnt_inc[7:0];
                    if (cnt_inc == C_TIMEOUT) begin
                        state_d       = S_ERR;
                        timeout_err_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    wait_cnt_d = 8'd0;
                    state_d    = S_RUN;
                end
            end
            default: begin
                // ERR is only left through reset.
                state_d       = S_ERR;
                timeout_err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            wait_cnt_q    <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;

    // ------------------------------------------------------------------
    // Optional saturating performance counters.
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_events_q, flush_events_d;
    logic        redirect_acc;

    // A redirect is accepted only when it actually flushes the pipe.
    assign redirect_acc = mem_redirect && !mem_busy && (state_q != S_ERR);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!pc_we && (state_q != S_ERR) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (redirect_acc && (flush_events_q != 16'hFFFF)) begin
            flush_events_d = flush_events_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
            flush_events_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = 16'd0;
    assign flush_events = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl with
//               MEM_TIMEOUT=4. Counter expectations follow HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int unsigned C_TIMEOUT = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit C_PERF_EN = 1'b1;
`else
    localparam bit C_PERF_EN = 1'b0;
`endif

    // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_fl, idex_fl, exmem_fl}
    localparam logic [7:0] C_NORMAL  = 8'b11111_000;
    localparam logic [7:0] C_FREEZE  = 8'b00000_000;
    localparam logic [7:0] C_LOADUSE = 8'b00111_010;
    localparam logic [7:0] C_REDIR   = 8'b11111_111;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memread, mem_redirect, mem_busy;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic        ifid_flush, idex_flush, exmem_flush, timeout_err;
    logic [15:0] stall_cycles, flush_events;
    logic [7:0]  ctl;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [15:0] exp_sc, exp_fe;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(C_TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .mem_redirect (mem_redirect),
        .mem_busy     (mem_busy),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idex_we      (idex_we),
        .exmem_we     (exmem_we),
        .memwb_we     (memwb_we),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .timeout_err  (timeout_err),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    assign ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                  ifid_flush, idex_flush, exmem_flush};

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_memread = 1'b0;
        mem_redirect = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        id_rs = 5'd5; ex_memread = 1'b1; ex_rt = 5'd5; mem_busy = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NORMAL);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_err);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
        end
        clear_inputs();
        edge_step();
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            failures++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, C_NORMAL);
        end
    endtask

    task automatic test_load_use();
        id_rs = 5'd5; ex_memread = 1'b1; ex_rt = 5'd5;
        #1;
        checks++;
        if (ctl !== C_LOADUSE) begin
            failures++; $display("FAIL load_use_rs got=%b exp=%b", ctl, C_LOADUSE);
        end
        edge_step();
        exp_stall++;
        // the bubble now sits in ID/EX
        ex_memread = 1'b0; ex_rt = 5'd0;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            failures++; $display("FAIL load_use_bubble got=%b exp=%b", ctl, C_NORMAL);
        end
        exp_sc = C_PERF_EN ? 16'(exp_stall) : 16'd0;
        checks++;
        if (stall_cycles !== exp_sc) begin
            failures++; $display("FAIL load_use_stall_cnt got=%0d exp=%0d", stall_cycles, exp_sc);
        end
        id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; ex_memread = 1'b1; ex_rt = 5'd7;
        #1;
        checks++;
        if (ctl !== C_LOADUSE) begin
            failures++; $display("FAIL load_use_rt got=%b exp=%b", ctl, C_LOADUSE);
        end
        id_uses_rt = 1'b0;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            failures++; $display("FAIL load_use_rt_unused got=%b exp=%b", ctl, C_NORMAL);
        end
        clear_inputs();
        edge_step();
    endtask

    task automatic test_zero_reg();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1;
        checks++;
        if (pc_we !== 1'b1 || ctl !== C_NORMAL) begin
            failures++; $display("FAIL zero_reg got=%b exp=%b", ctl, C_NORMAL);
        end
        clear_inputs();
        edge_step();
    endtask

    task automatic test_redirect();
        id_rs = 5'd5; ex_memread = 1'b1; ex_rt = 5'd5; mem_redirect = 1'b1;
        #1;
        checks++;
        if (ctl !== C_REDIR) begin
            failures++; $display("FAIL redirect_over_load_use got=%b exp=%b", ctl, C_REDIR);
        end
        edge_step();
        exp_flush++;
        clear_inputs();
        #1;
        exp_fe = C_PERF_EN ? 16'(exp_flush) : 16'd0;
        exp_sc = C_PERF_EN ? 16'(exp_stall) : 16'd0;
        checks++;
        if (flush_events !== exp_fe || stall_cycles !== exp_sc) begin
            failures++;
            $display("FAIL redirect_counters got=%0d/%0d exp=%0d/%0d",
                     flush_events, stall_cycles, exp_fe, exp_sc);
        end
    endtask

    task automatic test_busy_short();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== C_FREEZE) begin
                failures++; $display("FAIL busy_freeze_%0d got=%b exp=%b", i, ctl, C_FREEZE);
            end
            edge_step();
            exp_stall++;
        end
        mem_busy = 1'b0;
        #1;
        checks++;
        if (ctl !== C_NORMAL || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL busy_release got=%b/%b exp=%b/0", ctl, timeout_err, C_NORMAL);
        end
        edge_step();
        exp_sc = C_PERF_EN ? 16'(exp_stall) : 16'd0;
        checks++;
        if (ctl !== C_NORMAL || timeout_err !== 1'b0 || stall_cycles !== exp_sc) begin
            failures++;
            $display("FAIL busy_after got=%b/%b/%0d exp=%b/0/%0d",
                     ctl, timeout_err, stall_cycles, C_NORMAL, exp_sc);
        end
    endtask

    task automatic test_busy_redirect();
        mem_busy = 1'b1; mem_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ctl !== C_FREEZE) begin
                failures++; $display("FAIL busy_redirect_freeze_%0d got=%b exp=%b", i, ctl, C_FREEZE);
            end
            edge_step();
            exp_stall++;
        end
        mem_busy = 1'b0;
        #1;
        checks++;
        if (ctl !== C_REDIR) begin
            failures++; $display("FAIL busy_redirect_deferred got=%b exp=%b", ctl, C_REDIR);
        end
        edge_step();
        exp_flush++;
        clear_inputs();
        #1;
        exp_fe = C_PERF_EN ? 16'(exp_flush) : 16'd0;
        exp_sc = C_PERF_EN ? 16'(exp_stall) : 16'd0;
        checks++;
        if (flush_events !== exp_fe || stall_cycles !== exp_sc) begin
            failures++;
            $display("FAIL busy_redirect_counters got=%0d/%0d exp=%0d/%0d",
                     flush_events, stall_cycles, exp_fe, exp_sc);
        end
    endtask

    task automatic test_timeout();
        mem_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (timeout_err !== 1'b0 || ctl !== C_FREEZE) begin
                failures++;
                $display("FAIL timeout_pre_edge_%0d got=%b/%b exp=0/%b", i, timeout_err, ctl, C_FREEZE);
            end
            edge_step();
            exp_stall++;
        end
        checks++;
        if (timeout_err !== 1'b1 || ctl !== C_FREEZE) begin
            failures++;
            $display("FAIL timeout_entered got=%b/%b exp=1/%b", timeout_err, ctl, C_FREEZE);
        end
        // ERR ignores everything else
        mem_busy = 1'b0; mem_redirect = 1'b1;
        id_rs = 5'd9; ex_memread = 1'b1; ex_rt = 5'd9;
        #1;
        checks++;
        if (timeout_err !== 1'b1 || ctl !== C_FREEZE) begin
            failures++;
            $display("FAIL err_ignores_inputs got=%b/%b exp=1/%b", timeout_err, ctl, C_FREEZE);
        end
        edge_step();
        exp_sc = C_PERF_EN ? 16'(exp_stall) : 16'd0;
        exp_fe = C_PERF_EN ? 16'(exp_flush) : 16'd0;
        checks++;
        if (timeout_err !== 1'b1 || ctl !== C_FREEZE ||
            stall_cycles !== exp_sc || flush_events !== exp_fe) begin
            failures++;
            $display("FAIL err_sticky got=%b/%b/%0d/%0d exp=1/%b/%0d/%0d",
                     timeout_err, ctl, stall_cycles, flush_events, C_FREEZE, exp_sc, exp_fe);
        end
        // asynchronous reset pulse away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checks++;
        if (timeout_err !== 1'b0 || ctl !== C_NORMAL ||
            stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
            failures++;
            $display("FAIL async_reset got=%b/%b/%0d/%0d exp=0/%b/0/0",
                     timeout_err, ctl, stall_cycles, flush_events, C_NORMAL);
        end
        clear_inputs();
        edge_step();
        reset = 1'b0;
        mem_redirect = 1'b1;
        #1;
        checks++;
        if (ctl !== C_REDIR || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL run_after_reset got=%b/%b exp=%b/0", ctl, timeout_err, C_REDIR);
        end
        edge_step();
        exp_flush++;
        clear_inputs();
        #1;
        exp_fe = C_PERF_EN ? 16'(exp_flush) : 16'd0;
        checks++;
        if (flush_events !== exp_fe || ctl !== C_NORMAL) begin
            failures++;
            $display("FAIL run_after_reset_flush got=%0d/%b exp=%0d/%b",
                     flush_events, ctl, exp_fe, C_NORMAL);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_redirect();
        test_busy_short();
        test_busy_redirect();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL provide parameter MEM_TIMEOUT, default 255, the number of consecutive busy cycles tolerated from data memory before an error is declared.
REQ-002 The block SHALL have one clock and SHALL use an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock shared with the pipeline registers.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_rs, id_rt  input  5 each  source register fields of the instruction in IF/ID.
REQ-006 id_uses_rt  input  1  1 when the ID instruction reads rt as a source operand (R-type, beq, bne, sw).
REQ-007 ex_memread, ex_rt  input  1, 5  load flag and destination of the instruction in ID/EX.
REQ-008 mem_redirect  input  1  taken branch, jump or jr resolved at the EX/MEM register outputs.
REQ-009 mem_busy  input  1  data memory not ready this cycle.
REQ-010 pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  write enables for the PC and the pipeline registers.
REQ-011 ifid_flush, idex_flush, exmem_flush  output  1 each  load zeros, i.e. a bubble, into that register at the next edge.
REQ-012 timeout_err  output  1  sticky memory-timeout error flag.
REQ-013 stall_cycles, flush_events  output  16 each  performance counters.

Function
REQ-014 The hazard outputs SHALL be combinational from the current inputs and the registered state; there SHALL be zero added latency.
REQ-015 load_use SHALL be defined as ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
REQ-016 Priority SHALL be: ERR state > mem_busy > mem_redirect > load_use > normal run.
REQ-017 Normal run: all five write enables SHALL be 1 and all flushes SHALL be 0.
REQ-018 On load_use, pc_we and ifid_we SHALL be 0 and idex_flush SHALL be 1; all other enables SHALL be 1. This inserts exactly one bubble, because the bubble clears ex_memread on the next cycle.
REQ-019 On mem_redirect, all enables SHALL be 1 and ifid_flush, idex_flush and exmem_flush SHALL all be 1. The PC loads the target, and the three younger instructions are killed. A simultaneous load_use SHALL be ignored.
REQ-020 On mem_busy, all five enables SHALL be 0 and all flushes SHALL be 0 (full freeze). A simultaneous mem_redirect SHALL be deferred, because the frozen EX/MEM register holds it stable until busy drops.
REQ-021 The FSM SHALL have states RUN, WAIT and ERR:
  - RUN->WAIT at an edge where mem_busy=1.
  - WAIT->RUN at an edge where mem_busy=0.
  - WAIT->ERR when wait_cnt reaches MEM_TIMEOUT.
  - ERR SHALL be left only by reset.
REQ-022 wait_cnt SHALL be 8 bits. It SHALL increment at every edge with mem_busy=1 and clear at every edge with mem_busy=0. ERR SHALL be entered at the edge where the count of consecutive busy edges equals MEM_TIMEOUT.
REQ-023 In ERR, all enables and flushes SHALL be 0 and timeout_err SHALL be 1, regardless of the other inputs.
REQ-024 Load_use and redirect SHALL be evaluated only when mem_busy=0.

Reset
REQ-025 Assertion of reset SHALL immediately force state RUN, wait_cnt=0, timeout_err=0, stall_cycles=0 and flush_events=0, independent of clk.
REQ-026 While reset is high, the outputs SHALL be the normal-run values (enables 1, flushes 0). A reset mid-freeze or in ERR SHALL resume RUN on the first edge after release.

Configuration
REQ-027 When macro HAZARD_PERF_CNT_EN is defined:
  - stall_cycles SHALL increment at each edge where pc_we=0 outside ERR.
  - flush_events SHALL increment at each edge with mem_redirect accepted.
  - Both counters SHALL saturate at 16'hFFFF.
REQ-028 When HAZARD_PERF_CNT_EN is undefined, both counter ports SHALL remain present, SHALL be constant 0, and no counter flops SHALL be synthesized.

Verification
REQ-029 id_rs=5, ex_memread=1, ex_rt=5 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 in that cycle; exactly one bubble; stall_cycles=1 when enabled.
REQ-030 ex_memread=1, ex_rt=0, id_rs=0 -> no stall (pc_we=1).
REQ-031 mem_redirect=1 together with load_use=1 -> all three flushes=1, pc_we=1; flush_events increments by 1.
REQ-032 MEM_TIMEOUT=4; mem_busy high for 3 edges then low -> all enables 0 during busy, RUN afterwards, timeout_err=0.
REQ-033 MEM_TIMEOUT=4; mem_busy held high -> timeout_err=1 after the 4th edge and outputs stay frozen; async reset pulse mid-cycle -> timeout_err=0 immediately, RUN after release.
REQ-034 mem_busy=1 and mem_redirect=1 for 2 cycles, then busy=0 -> no flushes during busy; flushes asserted in the first non-busy cycle.
